// File: rtl/timer_bus_pkg.sv
// Shared definitions for the timer bus arbiter: FSM encoding and timer register map.
package timer_bus_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Timer slave register addresses
  localparam int unsigned AddrCtrl     = 0;
  localparam int unsigned AddrPeriod   = 1;
  localparam int unsigned AddrStatus   = 2;
  localparam int unsigned AddrChEn     = 3;
  localparam int unsigned AddrPulse12  = 4;
  localparam int unsigned AddrPulse34  = 5;
  localparam int unsigned AddrOnePulse = 6;
  localparam int unsigned AddrEvcnt    = 7;

  // Highest address the timer slave decodes
  localparam int unsigned AddrLimit = 7;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 valid
);

  // Scan from the pointer; the first hit wins and masks later candidates
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[(32'(ptr) + i) % NUM_REQ]) begin
        gnt[(32'(ptr) + i) % NUM_REQ] = 1'b1;
        valid                         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single timer slave, one transaction at a time.
module timer_bus_arbiter
  import timer_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ-1:0]            i_ReqWrite,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_ReqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_ReqWData,
  output logic [NUM_REQ-1:0]            o_Gnt,
  output logic [NUM_REQ-1:0]            o_Done,
  output logic [DATA_WIDTH-1:0]         o_RData,
  output logic                          o_Err,
  output logic                          o_WEnable,
  output logic [DATA_WIDTH-1:0]         o_WAddr,
  output logic [DATA_WIDTH-1:0]         o_WData,
  output logic                          o_REnable,
  output logic [DATA_WIDTH-1:0]         o_RAddr,
  input  logic [DATA_WIDTH-1:0]         i_RData,
  input  logic                          i_Err
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  write_q, write_d;
  logic                  oor_q, oor_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] raddr_q, raddr_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic                  arb_valid;
  logic [PtrW-1:0]       win_idx;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_oor;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .PTR_WIDTH(PtrW)
  ) u_rr_arbiter (
    .req  (i_Req),
    .ptr  (ptr_q),
    .gnt  (arb_gnt),
    .valid(arb_valid)
  );

  // Encode the one-hot winner to an index
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win_idx = PtrW'(i);
    end
  end

  assign sel_addr  = i_ReqAddr[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_wdata = i_ReqWData[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_oor   = (sel_addr > DATA_WIDTH'(AddrLimit));

  // Next-state and next registered-output logic; outputs default to idle values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    write_d = write_q;
    oor_d   = oor_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    raddr_d = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StIssue;
          ptr_d   = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          write_d = i_ReqWrite[win_idx];
          oor_d   = sel_oor;
          gnt_d   = arb_gnt;
          // Out-of-range accesses never reach the slave
          wen_d   = i_ReqWrite[win_idx] && !sel_oor;
          ren_d   = !i_ReqWrite[win_idx] && !sel_oor;
          waddr_d = sel_addr;
          wdata_d = sel_wdata;
          raddr_d = sel_addr;
        end
      end
      StIssue: begin
        state_d = StWait;
        gnt_d   = gnt_q;
      end
      StWait: begin
        // Slave response is valid now; capture it for the RESP cycle
        state_d = StResp;
        gnt_d   = gnt_q;
        done_d  = gnt_q;
        err_d   = oor_q ? 1'b1 : i_Err;
        rdata_d = (oor_q || write_q) ? '0 : i_RData;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      write_q <= 1'b0;
      oor_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      write_q <= write_d;
      oor_q   <= oor_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
    end
  end

  assign o_Gnt     = gnt_q;
  assign o_Done    = done_q;
  assign o_RData   = rdata_q;
  assign o_Err     = err_q;
  assign o_WEnable = wen_q;
  assign o_WAddr   = waddr_q;
  assign o_WData   = wdata_q;
  assign o_REnable = ren_q;
  assign o_RAddr   = raddr_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Directed bench for timer_bus_arbiter with a small register-file timer slave.
module tb_timer_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            srst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            wen;
  logic [DW-1:0]   waddr;
  logic [DW-1:0]   wdata_o;
  logic            ren;
  logic [DW-1:0]   raddr;
  logic [DW-1:0]   s_rdata;
  logic            s_err;
  logic [DW-1:0]   sregs [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_bus_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Req     (req),
    .i_ReqWrite(req_write),
    .i_ReqAddr (req_addr),
    .i_ReqWData(req_wdata),
    .o_Gnt     (gnt),
    .o_Done    (done),
    .o_RData   (rdata),
    .o_Err     (err),
    .o_WEnable (wen),
    .o_WAddr   (waddr),
    .o_WData   (wdata_o),
    .o_REnable (ren),
    .o_RAddr   (raddr),
    .i_RData   (s_rdata),
    .i_Err     (s_err)
  );

  // Timer slave: registered response; EVCNT (7) is read-only and errors on write
  always @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 8; i++) sregs[i] <= '0;
      s_rdata <= '0;
      s_err   <= 1'b0;
    end else begin
      s_rdata <= ren ? sregs[raddr[2:0]] : '0;
      s_err   <= wen && (waddr[2:0] == 3'd7);
      if (wen && waddr[2:0] != 3'd7) sregs[waddr[2:0]] <= wdata_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic wr, input logic [DW-1:0] a,
                         input logic [DW-1:0] d);
    req[k]               = 1'b1;
    req_write[k]         = wr;
    req_addr[k*DW +: DW] = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, DW'(gnt), '0);
    check({tag, "_done"}, DW'(done), '0);
    check({tag, "_wen"}, DW'(wen), '0);
    check({tag, "_ren"}, DW'(ren), '0);
    check({tag, "_err"}, DW'(err), '0);
    check({tag, "_rdata"}, rdata, '0);
    check({tag, "_waddr"}, waddr, '0);
    check({tag, "_wdata"}, wdata_o, '0);
    check({tag, "_raddr"}, raddr, '0);
  endtask

  initial begin
    rst       = 1'b1;
    srst      = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst  = 1'b0;
    srst = 1'b0;
    tick();

    // Single write: requester 0, addr 1, data 0x1234
    set_req(0, 1'b1, 32'd1, 32'h0000_1234);
    tick();
    check("wr_gnt", DW'(gnt), 32'h1);
    check("wr_wen", DW'(wen), 32'h1);
    check("wr_ren", DW'(ren), 32'h0);
    check("wr_waddr", waddr, 32'd1);
    check("wr_wdata", wdata_o, 32'h1234);
    tick();
    check("wr_wait_wen", DW'(wen), 32'h0);
    check("wr_wait_gnt", DW'(gnt), 32'h1);
    check("wr_wait_done", DW'(done), 32'h0);
    check("wr_wait_waddr", waddr, 32'h0);
    tick();
    check("wr_done", DW'(done), 32'h1);
    check("wr_err", DW'(err), 32'h0);
    check("wr_rdata", rdata, 32'h0);
    req = '0;
    tick();
    check("wr_after_gnt", DW'(gnt), 32'h0);
    check("wr_after_done", DW'(done), 32'h0);

    // Single read: requester 2, addr 1 (pointer is now 1)
    set_req(2, 1'b0, 32'd1, 32'h0);
    tick();
    check("rd_gnt", DW'(gnt), 32'h4);
    check("rd_ren", DW'(ren), 32'h1);
    check("rd_wen", DW'(wen), 32'h0);
    check("rd_raddr", raddr, 32'd1);
    tick();
    check("rd_wait_ren", DW'(ren), 32'h0);
    tick();
    check("rd_done", DW'(done), 32'h4);
    check("rd_rdata", rdata, 32'h1234);
    check("rd_err", DW'(err), 32'h0);
    req = '0;
    tick();

    // Out-of-range read: requester 1, addr 0x10 (pointer 3 -> wraps to 1)
    set_req(1, 1'b0, 32'h10, 32'h0);
    tick();
    check("oor_gnt", DW'(gnt), 32'h2);
    check("oor_ren", DW'(ren), 32'h0);
    check("oor_wen", DW'(wen), 32'h0);
    tick();
    tick();
    check("oor_done", DW'(done), 32'h2);
    check("oor_err", DW'(err), 32'h1);
    check("oor_rdata", rdata, 32'h0);
    req = '0;
    tick();

    // Write to EVCNT: requester 3, slave error propagates
    set_req(3, 1'b1, 32'd7, 32'h0000_abcd);
    tick();
    check("ev_gnt", DW'(gnt), 32'h8);
    check("ev_wen", DW'(wen), 32'h1);
    check("ev_waddr", waddr, 32'd7);
    tick();
    tick();
    check("ev_done", DW'(done), 32'h8);
    check("ev_err", DW'(err), 32'h1);
    check("ev_rdata", rdata, 32'h0);
    req = '0;
    tick();

    // Reset in WAIT: requester 1 reads addr 2 (pointer 0 -> winner 1)
    set_req(1, 1'b0, 32'd2, 32'h0);
    tick();
    check("rst_issue_gnt", DW'(gnt), 32'h2);
    tick();
    check("rst_wait_done", DW'(done), 32'h0);
    rst = 1'b1;
    req = '0;
    tick();
    check_idle_outputs("rst_mid");
    rst = 1'b0;

    // Contention: all four read addr k; grants from 0 regardless of old pointer
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, DW'(k), 32'h0);
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("ct%0d_issue_gnt", t), DW'(gnt), DW'(1 << (t % 4)));
      check($sformatf("ct%0d_issue_done", t), DW'(done), 32'h0);
      tick();
      check($sformatf("ct%0d_wait_gnt", t), DW'(gnt), DW'(1 << (t % 4)));
      check($sformatf("ct%0d_wait_done", t), DW'(done), 32'h0);
      tick();
      check($sformatf("ct%0d_resp_done", t), DW'(done), DW'(1 << (t % 4)));
      check($sformatf("ct%0d_resp_rdata", t), rdata, (t % 4 == 1) ? 32'h1234 : 32'h0);
      check($sformatf("ct%0d_resp_onehot", t), DW'($onehot0(gnt)), 32'h1);
      tick();
      check($sformatf("ct%0d_idle_gnt", t), DW'(gnt), 32'h0);
      check($sformatf("ct%0d_idle_done", t), DW'(done), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_bus_arbiter.md
TIMER_BUS_ARBITER -- requirements
Module: timer_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data and address width.
REQ-003 SHALL have port i_Clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_Req  input  NUM_REQ  per-requester transaction request, level.
REQ-006 SHALL have port i_ReqWrite  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
REQ-007 SHALL have port i_ReqAddr  input  NUM_REQ*DATA_WIDTH  packed per-requester address; requester k occupies slice k.
REQ-008 SHALL have port i_ReqWData  input  NUM_REQ*DATA_WIDTH  packed per-requester write data.
REQ-009 SHALL have port o_Gnt  output  NUM_REQ  one-hot grant, held from ISSUE through RESP.
REQ-010 SHALL have port o_Done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port o_RData / o_Err  output  DATA_WIDTH / 1  response data and error, valid while o_Done is high.
REQ-012 SHALL have port o_WEnable, o_WAddr, o_WData  output  1 / DATA_WIDTH / DATA_WIDTH  timer slave write port.
REQ-013 SHALL have port o_REnable, o_RAddr  output  1 / DATA_WIDTH  timer slave read port.
REQ-014 SHALL have port i_RData, i_Err  input  DATA_WIDTH / 1  timer slave response, registered by the slave one cycle after the enable.

Function
REQ-015 SHALL run a four-state FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Exactly one transaction is in flight at any time.
REQ-016 In IDLE with any i_Req bit high, SHALL pick a winner round-robin from the priority pointer.
- Latch index, op, address and data into registers; go to ISSUE.
- With no request, stay in IDLE.
REQ-017 SHALL set the round-robin pointer to (winner+1) mod NUM_REQ on each grant.
- Search order: pointer, pointer+1, ... wrapping.
REQ-018 In ISSUE, SHALL assert o_Gnt[winner] and drive the latched address and data.
- Write: o_WEnable=1 for exactly one cycle.
- Read: o_REnable=1 for exactly one cycle.
- Both enables SHALL never be high in the same cycle.
REQ-019 In WAIT, SHALL register i_RData and i_Err; enables are low.
REQ-020 In RESP, SHALL assert o_Done[winner] for one cycle with o_RData/o_Err valid, then return to IDLE.
- For writes, o_RData SHALL be 0.
REQ-021 Request-to-o_Done latency SHALL be 3 cycles after the IDLE sampling cycle; sustained throughput is one transaction per 4 cycles.
REQ-022 Out-of-range addresses (latched address bits [DATA_WIDTH-1:3] non-zero) SHALL NOT assert either enable.
- RESP reports o_Err=1, o_RData=0.
- Latency is unchanged.
REQ-023 A requester SHALL hold i_Req, i_ReqWrite, address and data stable until o_Done. A requester that keeps i_Req high in the cycle after o_Done is treated as a new request.
REQ-024 Request changes by non-granted requesters during ISSUE/WAIT/RESP SHALL NOT affect the in-flight transaction.
REQ-025 Outside ISSUE, o_WAddr/o_RAddr/o_WData SHALL be 0. All outputs SHALL be registered.

Reset
REQ-026 On i_Rst, the following SHALL clear in the same edge:
- State to IDLE, pointer to 0.
- o_Gnt, o_Done, o_WEnable, o_REnable, o_Err, o_RData, o_WAddr, o_RAddr, o_WData to 0.
REQ-027 Reset during ISSUE/WAIT/RESP SHALL abort the transaction: no o_Done is issued, and the slave enables drop next cycle.

Structure
REQ-028 Shared package timer_bus_pkg SHALL hold:
- FSM state encoding.
- Timer register address constants (CTRL=0, PERIOD=1, STATUS=2, CH_EN=3, PULSE12=4, PULSE34=5, ONEPULSE=6, EVCNT=7).
- Valid-address limit (7).
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, valid).

Verification
REQ-030 Single write: requester 0 writes addr 1, data 0x0000_1234 -> o_WEnable one cycle, o_WAddr=1, o_WData=0x1234; o_Done[0] 3 cycles later, o_Err=0.
REQ-031 Single read: requester 2 reads addr 1 after REQ-030 -> o_REnable one cycle; o_RData=0x0000_1234, o_Err=0 with o_Done[2].
REQ-032 Contention: all 4 requesters hold i_Req from reset release -> grants in order 0,1,2,3,0; o_Done spacing exactly 4 cycles; never two o_Gnt bits high.
REQ-033 Errors:
- Read addr 0x10 -> no enable; o_Err=1, o_RData=0.
- Write addr 7 -> enable issued; slave i_Err=1 propagates to o_Err=1.
REQ-034 Reset mid-operation: assert i_Rst in WAIT -> no o_Done; all outputs 0 next cycle; the next request is granted starting from requester 0.
